// File: rtl/correlator_sequencer.sv
// Sequencer for a time-multiplexed correlator: sweeps accumulator slots per strobe,
// drives the DSP/RAM pipeline enables and ping-pongs banks once per block of samples.
module correlator_sequencer #(
    parameter int PAIRS = 12,
    parameter int PBITS = 4,
    parameter int CBITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             strobe_i,
    input  logic [4:0]       blocksize_i,
    output logic [PBITS:0]   rd_addr_o,
    output logic             dsp_en_o,
    output logic             dsp_clr_o,
    output logic             dsp_vld_o,
    output logic             wr_en_o,
    output logic [PBITS:0]   wr_addr_o,
    output logic             bank_o,
    output logic             switch_o,
    output logic             busy_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t             state;
    logic [PBITS-1:0]   slot;
    logic [PBITS-1:0]   slot_nxt;
    logic [1:0]         drain;
    logic [CBITS-1:0]   cnt;
    logic [CBITS-1:0]   lim;
    logic [4:0]         bs;
    logic               first;
    logic               sweep_first;
    logic               sweep_bank;
    logic               rd_vld;
    logic [PBITS:0]     addr1;
    logic [PBITS:0]     addr2;

    assign slot_nxt = slot + 1'b1;
    assign rd_vld   = (state == SWEEP);
    // Last sample index of a block: 2^bs - 1.
    assign lim      = ~({CBITS{1'b1}} << bs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            drain       <= '0;
            cnt         <= '0;
            bs          <= 5'd1;
            first       <= 1'b1;
            sweep_first <= 1'b0;
            sweep_bank  <= 1'b0;
            bank_o      <= 1'b0;
            rd_addr_o   <= '0;
            busy_o      <= 1'b0;
            switch_o    <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            switch_o <= 1'b0;
            if (strobe_i && busy_o)
                overrun_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (strobe_i && enable_i) begin
                        state       <= SWEEP;
                        busy_o      <= 1'b1;
                        slot        <= '0;
                        sweep_bank  <= bank_o;
                        sweep_first <= first;
                        first       <= 1'b0;
                        rd_addr_o   <= {bank_o, {PBITS{1'b0}}};
                        if (first)
                            bs <= blocksize_i;
                    end
                end
                SWEEP: begin
                    if (slot == PBITS'(PAIRS - 1)) begin
                        state     <= DRAIN;
                        drain     <= '0;
                        rd_addr_o <= '0;
                    end else begin
                        slot      <= slot_nxt;
                        rd_addr_o <= {sweep_bank, slot_nxt};
                    end
                end
                DRAIN: begin
                    // Wait out the three pipeline stages before counting the sample.
                    if (drain == 2'd2) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        if (cnt == lim) begin
                            cnt      <= '0;
                            bank_o   <= ~bank_o;
                            switch_o <= 1'b1;
                            first    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and enables ride a 3-stage pipe matching DSP input, P-register and RAM write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsp_en_o  <= 1'b0;
            dsp_clr_o <= 1'b0;
            dsp_vld_o <= 1'b0;
            wr_en_o   <= 1'b0;
            addr1     <= '0;
            addr2     <= '0;
            wr_addr_o <= '0;
        end else begin
            dsp_en_o  <= rd_vld;
            dsp_clr_o <= rd_vld & sweep_first;
            addr1     <= rd_addr_o;
            dsp_vld_o <= dsp_en_o;
            addr2     <= addr1;
            wr_en_o   <= dsp_vld_o;
            wr_addr_o <= addr2;
        end
    end

endmodule
